residual_accumulator: RTL and testbench
=======================================

Name: residual_accumulator

Overview:
- Downstream consumer of the stage-3 sample controller.
- Each sample-ready strobe (stage 3's out_ready) presents one (x, y) pair loaded from the data memories. This block computes the model prediction y_hat = b0 + b1*x from the fitted coefficients, then the residual e = y - y_hat.
- Streams residuals out and accumulates the sum of squared errors (SSE) over the batch.
- A done pulse is raised after stage 3 signals end-of-batch (end3) and the pipeline has drained.

Parameters:
- DATA_W, 20, width of x, y, b0, b1 and residual; signed two's complement fixed point.
- FRAC, 10, fractional bits of all DATA_W quantities.
- ACC_W, 48, width of the SSE accumulator; unsigned.
- CNT_W, 8, width of the accepted-sample counter.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; arms the block for a new batch.
- sample_valid  input  1  connected to stage-3 out_ready; one sample per high cycle.
- last_in  input  1  connected to stage-3 end3; batch finished.
- x_in  input  DATA_W  sample x, valid with sample_valid.
- y_in  input  DATA_W  sample y, valid with sample_valid.
- b0_in  input  DATA_W  intercept; stable for the whole batch.
- b1_in  input  DATA_W  slope; stable for the whole batch.
- err_out  output  DATA_W  residual y - y_hat.
- err_valid  output  1  one-cycle strobe qualifying err_out.
- sse_out  output  ACC_W  running sum of (e*e) >>> FRAC.
- sample_cnt  output  CNT_W  samples accepted this batch; saturates at all-ones.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse at batch completion.

Behaviour:
- Reset: synchronous on rising clk while reset=1. State to IDLE. All outputs 0: err_out, err_valid, sse_out, sample_cnt, busy, done. All pipeline valid bits cleared. Reset overrides everything, including mid-batch; the partial batch is discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 -> RUN. sse_out and sample_cnt are cleared on the same edge.
  - RUN: a sample is accepted on each cycle with sample_valid=1. last_in=1 -> DRAIN. If sample_valid and last_in are high in the same cycle, that sample is still accepted.
  - DRAIN: counts 3 cycles, then -> DONE. Any sample_valid here is ignored.
  - DONE: done=1 for exactly one cycle -> IDLE. sse_out and sample_cnt hold until the next start.
- start outside IDLE is ignored. sample_valid and last_in outside RUN are ignored.
- Pipeline, each stage with its own valid bit:
  - S1 (edge after accept): p = b1*x, full 2*DATA_W signed product. Register y and b0.
  - S2: y_hat = b0 + (p >>> FRAC), arithmetic shift. Compute e = y - y_hat in DATA_W+2 bits, reduce to DATA_W per ERR_SAT_EN. Register err_out; err_valid=1. Latency from the accepting edge to err_valid high is 2 cycles.
  - S3: sq = (e*e) >>> FRAC, zero-extend, sse_out += sq. sse_out reflects the sample 3 cycles after accept.
- sse_out wraps modulo 2^ACC_W; no overflow flag.
- sample_cnt increments per accepted sample and holds at 2^CNT_W-1. A 150-sample batch fits.
- Back-to-back samples on consecutive cycles are fully supported; no stalls and no ready signal.

Optional Feature:
- Macro: ERR_SAT_EN.
- Defined: e is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: e is truncated to its low DATA_W bits (wraps).
- Squaring in S3 always uses the reduced DATA_W residual.

Test Plan:
- Single sample (Q10.10): start, then b0=1024, b1=2048, x=3072, y=8192 with sample_valid for 1 cycle, last_in next cycle.
  -> err_valid 2 cycles after accept with err_out=1024; sse_out=1024; sample_cnt=1; done pulses 1 cycle after DRAIN's 3 cycles.
- Full batch: 150 back-to-back samples, each with residual -512; last_in coincident with the 150th sample.
  -> 150 err_valid pulses, each err_out=-512 (0xFFE00); sse_out=150*256=38400; sample_cnt=150; exactly one done.
- Overflow: b0=0, b1=0, x=0, y=-524288 (wait y_hat=0 so e=-524288 fits; use b0=524287, y=-524288).
  -> ERR_SAT_EN defined: err_out=-524288. Undefined: err_out=0x00001 (wrapped).
- Ignored inputs: sample_valid pulses in IDLE and in DRAIN, and start during RUN.
  -> no err_valid from them; sample_cnt and FSM unaffected.
- Reset mid-batch: reset for 1 cycle after 5 accepted samples.
  -> next cycle all outputs 0, state IDLE, no done; a new start plus 1 sample gives sample_cnt=1.

Source files
------------

// File: rtl/residual_accumulator.sv
// residual_accumulator
//   Consumes (x, y) samples from the stage-3 sample controller, predicts
//   y_hat = b0 + b1*x from the fitted coefficients, streams out the residual
//   e = y - y_hat and accumulates the sum of squared errors over the batch.
//   A done pulse follows end-of-batch once the pipeline has drained.
//
//   Optional feature macro: ERR_SAT_EN
//     defined   : residual clamped to the signed DATA_W range
//     undefined : residual truncated to its low DATA_W bits (wraps)
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   start         one-cycle pulse, arms a new batch (IDLE only)
//   sample_valid  one sample per high cycle (RUN only)
//   last_in       end of batch (RUN only)
//   x_in, y_in    sample pair, signed Q(DATA_W-FRAC).FRAC
//   b0_in, b1_in  intercept / slope, stable for the batch
//   err_out       residual, qualified by err_valid
//   err_valid     one-cycle strobe
//   sse_out       running sum of (e*e) >>> FRAC, wraps modulo 2^ACC_W
//   sample_cnt    accepted samples this batch, saturating
//   busy          high in RUN and DRAIN
//   done          one-cycle pulse at batch completion
module residual_accumulator #(
  parameter int DATA_W = 20,
  parameter int FRAC   = 10,
  parameter int ACC_W  = 48,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sample_valid,
  input  logic              last_in,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  input  logic [DATA_W-1:0] b0_in,
  input  logic [DATA_W-1:0] b1_in,
  output logic [DATA_W-1:0] err_out,
  output logic              err_valid,
  output logic [ACC_W-1:0]  sse_out,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;
  logic [1:0] drain_q, drain_d;

  // Pipeline registers
  logic                       v0_q, v1_q, v2_q;
  logic [DATA_W-1:0]          x0_q, y0_q;
  logic signed [2*DATA_W-1:0] p_q;
  logic [DATA_W-1:0]          y1_q, b0_q;
  logic [DATA_W-1:0]          err_q;
  logic [ACC_W-1:0]           sse_q;
  logic [CNT_W-1:0]           cnt_q;

  logic accept, clear;
  assign accept = (state_q == RUN) && sample_valid;
  assign clear  = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        drain_d = '0;
        if (last_in) state_d = DRAIN;
      end
      DRAIN: begin
        // Three drain cycles cover the S1..S3 latency of the final sample.
        if (drain_q == 2'd2) state_d = DONE;
        else                 drain_d = drain_q + 2'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // S1 product
  logic signed [2*DATA_W-1:0] p_d;
  assign p_d = $signed(b1_in) * $signed(x0_q);

  // S2 residual, computed two bits wider than DATA_W before reduction
  logic signed [2*DATA_W-1:0] p_sh;
  logic [DATA_W+1:0]          e_wide;
  logic [DATA_W-1:0]          e_red;
  assign p_sh = p_q >>> FRAC;

  always_comb begin
    e_wide = {{2{y1_q[DATA_W-1]}}, y1_q} - {{2{b0_q[DATA_W-1]}}, b0_q}
             - p_sh[DATA_W+1:0];
`ifdef ERR_SAT_EN
    // In range exactly when the top three bits agree.
    if (e_wide[DATA_W+1:DATA_W-1] == '0 || e_wide[DATA_W+1:DATA_W-1] == '1)
      e_red = e_wide[DATA_W-1:0];
    else if (e_wide[DATA_W+1])
      e_red = {1'b1, {(DATA_W-1){1'b0}}};
    else
      e_red = {1'b0, {(DATA_W-1){1'b1}}};
`else
    e_red = e_wide[DATA_W-1:0];
`endif
  end

  // S3 square of the reduced residual; always non-negative
  logic signed [2*DATA_W-1:0] sq_full;
  logic [ACC_W-1:0]           sq;
  assign sq_full = $signed(err_q) * $signed(err_q);
  assign sq      = {{(ACC_W-2*DATA_W+FRAC){1'b0}}, sq_full[2*DATA_W-1:FRAC]};

  logic unused_bits;
  assign unused_bits = ^{p_sh[2*DATA_W-1:DATA_W+2], p_q[FRAC-1:0],
                         e_wide[DATA_W+1:DATA_W], sq_full[FRAC-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      drain_q <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      x0_q    <= '0;
      y0_q    <= '0;
      p_q     <= '0;
      y1_q    <= '0;
      b0_q    <= '0;
      err_q   <= '0;
      sse_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;

      v0_q <= accept;
      if (accept) begin
        x0_q <= x_in;
        y0_q <= y_in;
      end

      v1_q <= v0_q;
      if (v0_q) begin
        p_q  <= p_d;
        y1_q <= y0_q;
        b0_q <= b0_in;
      end

      v2_q <= v1_q;
      if (v1_q) err_q <= e_red;

      if (clear)     sse_q <= '0;
      else if (v2_q) sse_q <= sse_q + sq;

      if (clear)                       cnt_q <= '0;
      else if (accept && cnt_q != '1)  cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign err_out    = err_q;
  assign err_valid  = v2_q;
  assign sse_out    = sse_q;
  assign sample_cnt = cnt_q;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_residual_accumulator.sv
module tb_residual_accumulator;
  localparam int DW = 20;
  localparam int AW = 48;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, start, sample_valid, last_in;
  logic [DW-1:0] x_in, y_in, b0_in, b1_in;
  logic [DW-1:0] err_out;
  logic          err_valid;
  logic [AW-1:0] sse_out;
  logic [CW-1:0] sample_cnt;
  logic          busy, done;

  residual_accumulator #(.DATA_W(DW), .FRAC(10), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
    .last_in(last_in), .x_in(x_in), .y_in(y_in), .b0_in(b0_in), .b1_in(b1_in),
    .err_out(err_out), .err_valid(err_valid), .sse_out(sse_out),
    .sample_cnt(sample_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] err;
    int unsigned   acc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [DW-1:0] b0, b1, x, y;
    logic [DW-1:0] err;
    logic [AW-1:0] sq;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;
  int n_err  = 0;
  int n_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every residual must match and arrive 2 cycles after its accept edge.
  exp_t e_mon;
  always @(negedge clk) begin
    if (done) n_done++;
    if (err_valid) begin
      n_err++;
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL spurious err_valid: got err_out %0h expected no strobe", err_out);
      end else begin
        e_mon = sb.pop_front();
        check("err_out", 64'(err_out), 64'(e_mon.err));
        check("err latency", 64'(cyc - e_mon.acc), 64'd2);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] err);
    exp_t e;
    e.err = err;
    e.acc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic begin_batch;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  vec_t tbl[7];
  int   c, d0, e0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{b0: 20'd1024, b1: 20'd2048, x: 20'd3072, y: 20'd8192, err: 20'd1024, sq: 48'd1024};
    tbl[1] = '{b0: 20'd0, b1: 20'd1024, x: -20'sd2048, y: 20'd0, err: 20'd2048, sq: 48'd4096};
    tbl[2] = '{b0: -20'sd512, b1: -20'sd1024, x: 20'd1536, y: -20'sd3072, err: -20'sd1024, sq: 48'd1024};
    tbl[3] = '{b0: 20'd0, b1: 20'd1, x: -20'sd1, y: 20'd0, err: 20'd1, sq: 48'd0};
    tbl[4] = '{b0: 20'd0, b1: 20'd0, x: 20'd0, y: -20'sd512, err: 20'hFFE00, sq: 48'd256};
`ifdef ERR_SAT_EN
    tbl[5] = '{b0: 20'd524287, b1: 20'd0, x: 20'd0, y: 20'h80000, err: 20'h80000, sq: 48'd268435456};
    tbl[6] = '{b0: 20'h80000, b1: 20'd0, x: 20'd0, y: 20'd524287, err: 20'h7FFFF, sq: 48'd268434432};
`else
    tbl[5] = '{b0: 20'd524287, b1: 20'd0, x: 20'd0, y: 20'h80000, err: 20'h00001, sq: 48'd0};
    tbl[6] = '{b0: 20'h80000, b1: 20'd0, x: 20'd0, y: 20'd524287, err: 20'hFFFFF, sq: 48'd0};
`endif

    reset = 1'b1; start = 1'b0; sample_valid = 1'b0; last_in = 1'b0;
    x_in = '0; y_in = '0; b0_in = '0; b1_in = '0;
    tick(); tick();
    reset = 1'b0;
    check("reset err_out", 64'(err_out), 0);
    check("reset err_valid", 64'(err_valid), 0);
    check("reset sse_out", 64'(sse_out), 0);
    check("reset sample_cnt", 64'(sample_cnt), 0);
    check("reset busy", 64'(busy), 0);
    check("reset done", 64'(done), 0);

    // Single-sample batches from the vector table
    foreach (tbl[i]) begin
      b0_in = tbl[i].b0; b1_in = tbl[i].b1;
      begin_batch();
      check("busy in RUN", 64'(busy), 1);
      x_in = tbl[i].x; y_in = tbl[i].y; sample_valid = 1'b1;
      push(tbl[i].err);
      tick();
      sample_valid = 1'b0; last_in = 1'b1;
      tick();
      last_in = 1'b0;
      wait_done(c);
      check("done seen", 64'(done), 1);
      check("drain cycles", 64'(c), 3);
      check("vector sse", 64'(sse_out), 64'(tbl[i].sq));
      check("vector cnt", 64'(sample_cnt), 1);
      tick();
      check("done one cycle", 64'(done), 0);
      check("idle busy", 64'(busy), 0);
    end

    // Full batch: 150 back-to-back samples, residual -512, start during RUN ignored
    e0 = n_err; d0 = n_done;
    b0_in = '0; b1_in = 20'd1024;
    begin_batch();
    for (int i = 0; i < 150; i++) begin
      x_in = DW'(i); y_in = DW'(i) - 20'd512;
      sample_valid = 1'b1;
      last_in = (i == 149);
      start = (i == 70);
      push(20'hFFE00);
      tick();
    end
    sample_valid = 1'b0; last_in = 1'b0; start = 1'b0;
    tick();
    sample_valid = 1'b1;  // in DRAIN: must be ignored
    tick();
    sample_valid = 1'b0;
    wait_done(c);
    check("batch done", 64'(done), 1);
    check("batch sse", 64'(sse_out), 64'd38400);
    check("batch cnt", 64'(sample_cnt), 64'd150);
    tick();
    check("batch err pulses", 64'(n_err - e0), 64'd150);
    check("batch done pulses", 64'(n_done - d0), 1);

    // sample_valid in IDLE: no effect
    sample_valid = 1'b1; last_in = 1'b1;
    tick();
    sample_valid = 1'b0; last_in = 1'b0;
    tick(); tick(); tick();
    check("idle cnt hold", 64'(sample_cnt), 64'd150);
    check("idle sse hold", 64'(sse_out), 64'd38400);
    check("idle busy", 64'(busy), 0);

    // Counter saturation: 260 zero-residual samples
    b0_in = '0; b1_in = '0; x_in = '0; y_in = '0;
    begin_batch();
    for (int i = 0; i < 260; i++) begin
      sample_valid = 1'b1;
      last_in = (i == 259);
      push('0);
      tick();
    end
    sample_valid = 1'b0; last_in = 1'b0;
    wait_done(c);
    check("sat done", 64'(done), 1);
    check("sat cnt", 64'(sample_cnt), 64'd255);
    check("sat sse", 64'(sse_out), 0);
    tick();

    // Reset mid-batch after 5 accepted samples; samples 4 and 5 are discarded
    b0_in = '0; b1_in = 20'd1024;
    begin_batch();
    for (int i = 0; i < 5; i++) begin
      x_in = DW'(i + 7); y_in = DW'(i + 7) - 20'd512;
      sample_valid = 1'b1;
      if (i < 3) push(20'hFFE00);
      tick();
    end
    sample_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid reset err_out", 64'(err_out), 0);
    check("mid reset err_valid", 64'(err_valid), 0);
    check("mid reset sse", 64'(sse_out), 0);
    check("mid reset cnt", 64'(sample_cnt), 0);
    check("mid reset busy", 64'(busy), 0);
    check("mid reset done", 64'(done), 0);
    d0 = n_done;
    repeat (6) tick();
    check("no done after reset", 64'(n_done), 64'(d0));
    check("idle after reset", 64'(busy), 0);
    begin_batch();
    x_in = 20'd3; y_in = 20'd3 - 20'd512; sample_valid = 1'b1;
    push(20'hFFE00);
    tick();
    sample_valid = 1'b0; last_in = 1'b1;
    tick();
    last_in = 1'b0;
    wait_done(c);
    check("post reset done", 64'(done), 1);
    check("post reset cnt", 64'(sample_cnt), 1);
    check("post reset sse", 64'(sse_out), 64'd256);
    tick(); tick();

    check("scoreboard drained", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
